// File: rtl/mrelbp_rd_score_acc.sv
// mrelbp_rd_score_acc
//   Takes a stream of 8-bit RD LBP codes, uses each one as the address of a
//   combinational-read weight ROM, and accumulates the signed weights over a
//   frame. At end of frame the stage presents the score, the pixel count and a
//   saturation flag on a valid/ready handshake.
//
// Ports
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_code_valid      code beat valid
//   i_code            RD LBP code
//   i_sof, i_eof      first / last pixel of frame (qualified by i_code_valid)
//   o_code_ready      stage can accept a code beat (IDLE or ACCUM)
//   o_lut_addr        registered ROM address
//   i_lut_dout        ROM weight for o_lut_addr, same cycle
//   o_score_valid     score/count/sat valid (DONE)
//   i_score_ready     consumer accepts the score
//   o_score           accumulated signed score
//   o_pix_cnt         pixels accumulated in the frame
//   o_sat             accumulator clamped at least once this frame
//   o_err             sticky protocol error, cleared by reset only
module mrelbp_rd_score_acc #(
  parameter int unsigned CODE_W = 8,
  parameter int unsigned WGT_W  = 24,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned CNT_W  = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_code_valid,
  input  logic [CODE_W-1:0] i_code,
  input  logic              i_sof,
  input  logic              i_eof,
  output logic              o_code_ready,
  output logic [CODE_W-1:0] o_lut_addr,
  input  logic [WGT_W-1:0]  i_lut_dout,
  output logic              o_score_valid,
  input  logic              i_score_ready,
  output logic [ACC_W-1:0]  o_score,
  output logic [CNT_W-1:0]  o_pix_cnt,
  output logic              o_sat,
  output logic              o_err
);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_e;

  state_e state;
  logic   v1;
  logic   sof1;

  logic             accept;
  logic             take;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W:0]   sum_wide;
  logic             ovf;
  logic [ACC_W-1:0] sum_clamped;
  logic [ACC_W-1:0] acc_max;
  logic [ACC_W-1:0] acc_min;

  // Ready is gated by the reset input so it reads 0 while reset is held.
  assign o_code_ready = i_rst_n & ((state == StIdle) | (state == StAccum));
  assign accept       = i_code_valid & o_code_ready;
  // Beats arriving in IDLE without sof are dropped and never enter the pipe.
  assign take         = accept & (i_sof | (state == StAccum));

  assign w_ext   = ACC_W'($signed(i_lut_dout));
  assign acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  assign acc_min = {1'b1, {(ACC_W-1){1'b0}}};

  // One guard bit: overflow when the two top bits of the widened sum differ.
  assign sum_wide = {o_score[ACC_W-1], o_score} + {w_ext[ACC_W-1], w_ext};
  assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

  always_comb begin
    sum_clamped = sum_wide[ACC_W-1:0];
    if (ovf) begin
      sum_clamped = sum_wide[ACC_W] ? acc_min : acc_max;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= StIdle;
      v1            <= 1'b0;
      sof1          <= 1'b0;
      o_lut_addr    <= '0;
      o_score_valid <= 1'b0;
      o_score       <= '0;
      o_pix_cnt     <= '0;
      o_sat         <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      // S1: register the address and the beat tags.
      v1 <= take;
      if (take) begin
        o_lut_addr <= i_code;
        sof1       <= i_sof;
      end

      // S2: accumulate the weight read back for the S1 address.
      if (v1) begin
        if (sof1) begin
          o_score   <= w_ext;
          o_pix_cnt <= CNT_W'(1);
          o_sat     <= 1'b0;
        end else begin
          o_score   <= sum_clamped;
          o_pix_cnt <= (&o_pix_cnt) ? o_pix_cnt : o_pix_cnt + CNT_W'(1);
          o_sat     <= o_sat | ovf;
        end
      end

      unique case (state)
        StIdle: begin
          if (accept) begin
            if (i_sof) begin
              state <= i_eof ? StDrain : StAccum;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        StAccum: begin
          if (accept) begin
            // A sof here restarts the frame through the sof1 tag.
            if (i_sof) begin
              o_err <= 1'b1;
            end
            if (i_eof) begin
              state <= StDrain;
            end
          end
        end
        StDrain: begin
          state         <= StDone;
          o_score_valid <= 1'b1;
        end
        StDone: begin
          if (i_score_ready) begin
            state         <= StIdle;
            o_score_valid <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mrelbp_rd_score_acc.sv
// Scoreboard bench for mrelbp_rd_score_acc. A frame-level model predicts the
// score of each frame as beats are accepted; a monitor pops and compares on
// every score handshake. A second instance with a 24-bit accumulator and a
// ROM stuck at +max exercises the clamp.
module tb_mrelbp_rd_score_acc;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned WGT_W  = 24;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned CNT_W  = 20;

  logic              clk = 1'b0;
  logic              i_rst_n;
  logic              i_code_valid;
  logic [CODE_W-1:0] i_code;
  logic              i_sof, i_eof;
  logic              o_code_ready;
  logic [CODE_W-1:0] o_lut_addr;
  logic [WGT_W-1:0]  i_lut_dout;
  logic              o_score_valid;
  logic              i_score_ready;
  logic [ACC_W-1:0]  o_score;
  logic [CNT_W-1:0]  o_pix_cnt;
  logic              o_sat, o_err;

  // Second instance: 24-bit accumulator, ROM forced to +max.
  logic              b_valid, b_sof, b_eof, b_ready, b_svalid, b_sready, b_sat, b_err;
  logic [CODE_W-1:0] b_code, b_addr;
  logic [WGT_W-1:0]  b_dout;
  logic [23:0]       b_score;
  logic [CNT_W-1:0]  b_cnt;

  always #5 clk = ~clk;

  // ROM model: mem[a] = a - 128, sign-extended to 24 bits.
  assign i_lut_dout = WGT_W'(int'(o_lut_addr) - 128);
  assign b_dout     = 24'h7FFFFF;

  mrelbp_rd_score_acc #(.CODE_W(CODE_W), .WGT_W(WGT_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_code_valid(i_code_valid), .i_code(i_code),
    .i_sof(i_sof), .i_eof(i_eof), .o_code_ready(o_code_ready), .o_lut_addr(o_lut_addr),
    .i_lut_dout(i_lut_dout), .o_score_valid(o_score_valid), .i_score_ready(i_score_ready),
    .o_score(o_score), .o_pix_cnt(o_pix_cnt), .o_sat(o_sat), .o_err(o_err)
  );

  mrelbp_rd_score_acc #(.CODE_W(CODE_W), .WGT_W(WGT_W), .ACC_W(24), .CNT_W(CNT_W)) dut_b (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_code_valid(b_valid), .i_code(b_code),
    .i_sof(b_sof), .i_eof(b_eof), .o_code_ready(b_ready), .o_lut_addr(b_addr),
    .i_lut_dout(b_dout), .o_score_valid(b_svalid), .i_score_ready(b_sready),
    .o_score(b_score), .o_pix_cnt(b_cnt), .o_sat(b_sat), .o_err(b_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  typedef struct {
    longint score;
    longint cnt;
    bit     sat;
  } exp_t;

  exp_t   sb[$];
  bit     m_in_frame = 0;
  longint m_acc      = 0;
  longint m_cnt      = 0;
  bit     m_sat      = 0;
  bit     m_err      = 0;

  localparam longint AccMax = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint AccMin = -(longint'(1) <<< (ACC_W - 1));

  // Returns 1 when the accepted beat closes a frame.
  function automatic bit model_accept(input logic [7:0] code, input bit sof, input bit eof);
    exp_t e;
    if (!m_in_frame && !sof) begin
      m_err = 1;
      return 0;
    end
    if (m_in_frame && sof) m_err = 1;
    if (sof) begin
      m_acc      = 0;
      m_cnt      = 0;
      m_sat      = 0;
      m_in_frame = 1;
    end
    m_acc = m_acc + (longint'(code) - 128);
    if (m_acc > AccMax) begin m_acc = AccMax; m_sat = 1; end
    if (m_acc < AccMin) begin m_acc = AccMin; m_sat = 1; end
    if (m_cnt < (longint'(1) <<< CNT_W) - 1) m_cnt++;
    if (eof) begin
      e.score = m_acc;
      e.cnt   = m_cnt;
      e.sat   = m_sat;
      sb.push_back(e);
      m_in_frame = 0;
      return 1;
    end
    return 0;
  endfunction

  // ---------------- score-ready driver ----------------
  int rdy_mode = 1;  // 0 random, 1 held low, 2 held high
  initial i_score_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       i_score_ready = 1'($urandom_range(0, 1));
      1:       i_score_ready = 1'b0;
      default: i_score_ready = 1'b1;
    endcase
  end

  // ---------------- monitor ----------------
  bit               hold = 0;
  logic [ACC_W-1:0] h_score;
  logic [CNT_W-1:0] h_cnt;
  logic             h_sat;

  always @(negedge clk) begin
    if (!i_rst_n) begin
      hold = 0;
    end else if (o_score_valid) begin
      if (hold) begin
        check("score_stable", longint'(o_score), longint'(h_score));
        check("cnt_stable", longint'(o_pix_cnt), longint'(h_cnt));
        check("sat_stable", longint'(o_sat), longint'(h_sat));
        check("ready_low_in_done", longint'(o_code_ready), 0);
      end
      if (i_score_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_score", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("score", longint'($signed(o_score)), e.score);
          check("pix_cnt", longint'(o_pix_cnt), e.cnt);
          check("sat", longint'(o_sat), longint'(e.sat));
        end
        hold = 0;
      end else begin
        hold    = 1;
        h_score = o_score;
        h_cnt   = o_pix_cnt;
        h_sat   = o_sat;
      end
    end else begin
      hold = 0;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_beat(input logic [7:0] code, input bit sof, input bit eof);
    int guard = 0;
    @(negedge clk);
    i_code_valid = 1'b1;
    i_code       = code;
    i_sof        = sof;
    i_eof        = eof;
    while (!o_code_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      check("code_ready_timeout", 0, 1);
      i_code_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 i_code_valid = 1'b0;
    if (model_accept(code, sof, eof)) begin
      // Eof accepted at this edge: DRAIN next cycle, score valid one after.
      @(negedge clk);
      check("valid_not_early", longint'(o_score_valid), 0);
      @(negedge clk);
      check("valid_latency", longint'(o_score_valid), 1);
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((sb.size() != 0 || o_score_valid) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) check("drain_timeout", 0, 1);
  endtask

  task automatic run_random();
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 7) == 0) send_beat(8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < len; i++) begin
        bit s;
        s = (i == 0) || ($urandom_range(0, 15) == 0);
        send_beat(8'($urandom), s, i == len - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    i_rst_n      = 1'b0;
    i_code_valid = 1'b0;
    i_code       = '0;
    i_sof        = 1'b0;
    i_eof        = 1'b0;
    b_valid      = 1'b0;
    b_code       = '0;
    b_sof        = 1'b0;
    b_eof        = 1'b0;
    b_sready     = 1'b0;

    // 1. reset values
    repeat (3) @(negedge clk);
    check("ready_in_reset", longint'(o_code_ready), 0);
    check("valid_in_reset", longint'(o_score_valid), 0);
    i_rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", longint'(o_code_ready), 1);
    check("lut_addr_reset", longint'(o_lut_addr), 0);
    check("score_reset", longint'(o_score), 0);
    check("cnt_reset", longint'(o_pix_cnt), 0);
    check("sat_reset", longint'(o_sat), 0);
    check("err_reset", longint'(o_err), 0);

    // 2. {0,255,128}, consumer stalls 5 cycles
    rdy_mode = 1;
    send_beat(8'd0, 1'b1, 1'b0);
    send_beat(8'd255, 1'b0, 1'b0);
    send_beat(8'd128, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    rdy_mode = 2;
    wait_drain();
    @(negedge clk);
    check("ready_after_handshake", longint'(o_code_ready), 1);

    // 3. single-beat frame
    send_beat(8'd200, 1'b1, 1'b1);
    wait_drain();
    check("err_clean", longint'(o_err), 0);

    // 5. stray beat in IDLE, then {10, sof 20, 30 eof}
    send_beat(8'd5, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("err_stray_beat", longint'(o_err), longint'(m_err));
    send_beat(8'd10, 1'b0, 1'b0);
    send_beat(8'd20, 1'b1, 1'b0);
    send_beat(8'd30, 1'b0, 1'b1);
    wait_drain();

    // Randomised frames with random consumer backpressure
    rdy_mode = 0;
    run_random();
    rdy_mode = 2;
    wait_drain();
    check("err_after_random", longint'(o_err), longint'(m_err));

    // 6. reset mid-frame
    send_beat(8'd129, 1'b1, 1'b0);
    send_beat(8'd3, 1'b0, 1'b0);
    @(negedge clk);
    i_rst_n    = 1'b0;
    m_in_frame = 0;
    m_err      = 0;
    #1;
    check("ready_mid_reset", longint'(o_code_ready), 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_valid_after_reset", longint'(o_score_valid), 0);
    end
    check("err_cleared_by_reset", longint'(o_err), 0);
    send_beat(8'd129, 1'b0, 1'b1);  // no sof: dropped
    repeat (2) @(negedge clk);
    check("err_no_sof", longint'(o_err), longint'(m_err));
    i_rst_n = 1'b0;
    m_err   = 0;
    @(negedge clk);
    i_rst_n = 1'b1;
    send_beat(8'd129, 1'b1, 1'b1);
    wait_drain();
    check("err_final", longint'(o_err), 0);

    // 4. 24-bit accumulator saturation
    begin
      int g;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        b_valid = 1'b1;
        b_code  = 8'(i);
        b_sof   = (i == 0);
        b_eof   = (i == 2);
        check("b_ready", longint'(b_ready), 1);
      end
      @(negedge clk);
      b_valid = 1'b0;
      g = 0;
      while (!b_svalid && g < 20) begin
        @(negedge clk);
        g++;
      end
      check("b_valid_seen", longint'(b_svalid), 1);
      check("b_score_max", longint'(b_score), longint'(24'h7FFFFF));
      check("b_sat", longint'(b_sat), 1);
      check("b_cnt", longint'(b_cnt), 3);
      b_sready = 1'b1;
      @(negedge clk);
      check("b_valid_cleared", longint'(b_svalid), 0);
    end

    check("scoreboard_empty", longint'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
